// File: rtl/score_display_ctrl_pkg.sv
// Shared constants for the score display: adder state codes, blank pattern, BCD limits.
package score_display_ctrl_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ADD    = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] BCD_MAX   = 4'd9;

    // Out-of-range BCD inputs (10..15) are treated as the largest digit.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] v);
        return (v > BCD_MAX) ? BCD_MAX : v;
    endfunction

endpackage

// File: rtl/score_display_ctrl_hex_seg.sv
// Hex to active-low 7-segment decoder (gfedcba); codes 16..31 render blank.
module score_display_ctrl_hex_seg
    import score_display_ctrl_pkg::*;
(
    input  logic [4:0] value,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (value)
            5'd0:  seg = 7'h40;
            5'd1:  seg = 7'h79;
            5'd2:  seg = 7'h24;
            5'd3:  seg = 7'h30;
            5'd4:  seg = 7'h19;
            5'd5:  seg = 7'h12;
            5'd6:  seg = 7'h02;
            5'd7:  seg = 7'h78;
            5'd8:  seg = 7'h00;
            5'd9:  seg = 7'h10;
            5'd10: seg = 7'h08;
            5'd11: seg = 7'h03;
            5'd12: seg = 7'h46;
            5'd13: seg = 7'h21;
            5'd14: seg = 7'h06;
            5'd15: seg = 7'h0E;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_display_ctrl.sv
// BCD score register with a digit-serial adder, plus a scanned 7-segment display
// with leading-zero blanking and game-over blink.
module score_display_ctrl
    import score_display_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_DIV  = 64
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    add_pulse,
    input  logic [3:0]              add_value,
    output logic                    add_ready,
    input  logic                    clear_score,
    input  logic                    game_over,
    output logic [4*NUM_DIGITS-1:0] score_bcd,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic [6:0]              seg_out
);

    localparam int PW = $clog2(NUM_DIGITS);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(NUM_DIGITS - 1);

    logic [1:0]                 state;
    logic [NUM_DIGITS-1:0][3:0] score;
    logic [NUM_DIGITS-1:0][3:0] work;
    logic [3:0]                 operand;
    logic [PW-1:0]              ptr;
    logic                       carry;

    logic [3:0] addend;
    logic [4:0] sum;
    logic       sum_carry;
    logic [3:0] digit_next;

    assign score_bcd = score;
    assign add_ready = (state == ST_IDLE);

    // Only digit 0 receives the operand; higher digits just absorb the carry.
    always_comb begin
        addend     = (ptr == '0) ? operand : 4'd0;
        sum        = {1'b0, work[ptr]} + {1'b0, addend} + {4'd0, carry};
        sum_carry  = (sum > 5'd9);
        digit_next = sum_carry ? (sum[3:0] - 4'd10) : sum[3:0];
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            score   <= '0;
            work    <= '0;
            operand <= '0;
            ptr     <= '0;
            carry   <= 1'b0;
        end else if (clear_score) begin
            state <= ST_IDLE;
            score <= '0;
            ptr   <= '0;
            carry <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (add_pulse) begin
                        operand <= bcd_clamp(add_value);
                        work    <= score;
                        ptr     <= '0;
                        carry   <= 1'b0;
                        state   <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    work[ptr] <= digit_next;
                    carry     <= sum_carry;
                    if (ptr == LAST) state <= ST_COMMIT;
                    else             ptr   <= ptr + 1'b1;
                end
                ST_COMMIT: begin
                    // Carry out of the top digit means overflow: pin at all nines.
                    score <= carry ? {NUM_DIGITS{BCD_MAX}} : work;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic [SW-1:0] presc;
    logic [PW-1:0] idx;
    logic          scan_wrap;
    logic          rot_wrap;

    assign scan_wrap = (presc == SW'(SCAN_DIV - 1));
    assign rot_wrap  = scan_wrap && (idx == LAST);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            presc <= '0;
            idx   <= '0;
        end else if (scan_wrap) begin
            presc <= '0;
            idx   <= (idx == LAST) ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    logic [BW-1:0] bcnt;
    logic          hidden;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            bcnt   <= '0;
            hidden <= 1'b0;
        end else if (!game_over) begin
            bcnt   <= '0;
            hidden <= 1'b0;
        end else if (rot_wrap) begin
            if (bcnt == BW'(BLINK_DIV - 1)) begin
                bcnt   <= '0;
                hidden <= ~hidden;
            end else begin
                bcnt <= bcnt + 1'b1;
            end
        end
    end

    logic       lz_blank;
    logic [6:0] dec_seg;
    logic [6:0] seg_q;

    // A non-zero digit at or above the scanned position keeps it visible.
    always_comb begin
        lz_blank = (idx != '0);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((PW'(i) >= idx) && (score[i] != 4'd0)) lz_blank = 1'b0;
        end
    end

    score_display_ctrl_hex_seg u_hex_seg (
        .value ({1'b0, score[idx]}),
        .seg   (dec_seg)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            seg_q    <= SEG_BLANK;
            digit_en <= NUM_DIGITS'(1);
        end else begin
            seg_q    <= lz_blank ? SEG_BLANK : dec_seg;
            digit_en <= NUM_DIGITS'(1) << idx;
        end
    end

    assign seg_out = hidden ? SEG_BLANK : seg_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed and randomized checks of score_display_ctrl against an integer score model.
module tb_score_display_ctrl;

    localparam int N = 4;
    localparam int S = 2;
    localparam int B = 1;
    localparam int MAXV = 9999;

    logic           clock = 1'b0;
    logic           resetn = 1'b0;
    logic           add_pulse = 1'b0;
    logic [3:0]     add_value = 4'd0;
    logic           add_ready;
    logic           clear_score = 1'b0;
    logic           game_over = 1'b0;
    logic [4*N-1:0] score_bcd;
    logic [N-1:0]   digit_en;
    logic [6:0]     seg_out;

    int vectors = 0;
    int miscompares = 0;
    int model = 0;
    int hidden_seen = 0;
    int unsigned ecnt;
    bit ph_hidden;

    logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    score_display_ctrl #(.NUM_DIGITS(N), .SCAN_DIV(S), .BLINK_DIV(B)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .add_pulse   (add_pulse),
        .add_value   (add_value),
        .add_ready   (add_ready),
        .clear_score (clear_score),
        .game_over   (game_over),
        .score_bcd   (score_bcd),
        .digit_en    (digit_en),
        .seg_out     (seg_out)
    );

    always #5 clock = ~clock;

    // Edge count since reset release; blink phase flips once per full rotation.
    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ecnt      <= 0;
            ph_hidden <= 1'b0;
        end else begin
            ecnt <= ecnt + 1;
            if (!game_over)                      ph_hidden <= 1'b0;
            else if (((ecnt + 1) % (S * N)) == 0) ph_hidden <= ~ph_hidden;
        end
    end

    function automatic int pow10(input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [4*N-1:0] to_bcd(input int v);
        logic [4*N-1:0] r = '0;
        for (int i = 0; i < N; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One display sample at a negedge, assuming the score has been stable.
    task automatic chk_display();
        int id, dv;
        logic [6:0] exp_seg;
        id = ((ecnt - 1) / S) % N;
        dv = (model / pow10(id)) % 10;
        if (ph_hidden)                      exp_seg = 7'h7F;
        else if (id > 0 && model < pow10(id)) exp_seg = 7'h7F;
        else                                exp_seg = seg_tbl[dv];
        if (ph_hidden) hidden_seen++;
        chk("digit_en", 32'(digit_en), 32'(1 << id));
        chk("seg_out", 32'(seg_out), 32'(exp_seg));
    endtask

    task automatic scan_check(input int cycles);
        @(negedge clock);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clock);
            chk_display();
        end
    endtask

    task automatic do_add(input int v);
        int n;
        chk("ready_before_add", 32'(add_ready), 32'd1);
        add_pulse = 1'b1;
        add_value = 4'(v);
        @(negedge clock);
        add_pulse = 1'b0;
        n = 0;
        while (add_ready !== 1'b1 && n < 20) begin
            n++;
            @(negedge clock);
        end
        model = model + ((v > 9) ? 9 : v);
        if (model > MAXV) model = MAXV;
        chk("add_busy_cycles", 32'(n), 32'(N + 1));
        chk("score_after_add", 32'(score_bcd), 32'(to_bcd(model)));
    endtask

    task automatic do_clear();
        clear_score = 1'b1;
        @(negedge clock);
        clear_score = 1'b0;
        model = 0;
        chk("clear_score_val", 32'(score_bcd), 32'd0);
        chk("clear_ready", 32'(add_ready), 32'd1);
    endtask

    initial begin
        int v, n;

        // Reset state
        #12;
        chk("rst_score", 32'(score_bcd), 32'd0);
        chk("rst_ready", 32'(add_ready), 32'd1);
        chk("rst_digit_en", 32'(digit_en), 32'd1);
        chk("rst_seg", 32'(seg_out), 32'h7F);
        @(negedge clock);
        resetn = 1'b1;
        scan_check(2 * S * N);

        // 7 + 5 = 12, digit 1 shows "1", upper digits blank
        do_add(7);
        do_add(5);
        chk("score_12", 32'(score_bcd), 32'h0012);
        scan_check(2 * S * N);

        // Pulse while busy is dropped
        add_pulse = 1'b1; add_value = 4'd6;
        @(negedge clock);
        add_pulse = 1'b0;
        @(negedge clock);
        chk("busy_ready_low", 32'(add_ready), 32'd0);
        add_pulse = 1'b1; add_value = 4'd3;
        @(negedge clock);
        add_pulse = 1'b0;
        n = 0;
        while (add_ready !== 1'b1 && n < 20) begin n++; @(negedge clock); end
        model += 6;
        chk("drop_wait", 32'(n < 20), 32'd1);
        repeat (8) @(negedge clock);
        chk("drop_score", 32'(score_bcd), 32'(to_bcd(model)));
        chk("drop_ready", 32'(add_ready), 32'd1);

        // Clear during ADD discards the in-flight add
        add_pulse = 1'b1; add_value = 4'd4;
        @(negedge clock);
        add_pulse = 1'b0;
        @(negedge clock);
        do_clear();
        repeat (8) @(negedge clock);
        chk("clr_inflight_score", 32'(score_bcd), 32'd0);
        chk("clr_inflight_ready", 32'(add_ready), 32'd1);

        // Clear beats a simultaneous add
        do_add(8);
        add_pulse = 1'b1; add_value = 4'd5;
        do_clear();
        add_pulse = 1'b0;
        repeat (6) @(negedge clock);
        chk("clr_vs_add_score", 32'(score_bcd), 32'd0);

        // Randomized adds (values 10..15 clamp to 9) with occasional clears
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 9) == 0) do_clear();
            else begin
                v = $urandom_range(0, 15);
                do_add(v);
            end
            if (k % 12 == 11) scan_check(S * N + 1);
        end

        // Climb to 9998, then overflow saturates at 9999
        do_clear();
        for (int k = 0; k < 1110; k++) do_add(9);
        do_add(8);
        chk("score_9998", 32'(score_bcd), 32'h9998);
        do_add(9);
        chk("saturate_9999", 32'(score_bcd), 32'h9999);
        do_add(15);
        chk("stay_9999", 32'(score_bcd), 32'h9999);
        scan_check(S * N);

        // Game-over blink with a partially blanked score
        do_clear();
        do_add(3);
        do_add(9);
        game_over = 1'b1;
        hidden_seen = 0;
        for (int c = 0; c < 4 * S * N; c++) begin
            @(negedge clock);
            chk_display();
        end
        chk("blink_hidden_seen", 32'(hidden_seen > 0), 32'd1);
        game_over = 1'b0;
        @(negedge clock);
        chk("blink_off_visible", 32'(ph_hidden), 32'd0);
        chk_display();
        for (int c = 0; c < S * N; c++) begin
            @(negedge clock);
            chk_display();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/score_display_ctrl.md
Name: score_display_ctrl

Overview:
- Holds the player score as NUM_DIGITS packed BCD digits and updates it with a multi-cycle, digit-serial BCD adder.
- Shares a single hex_seg decoder across all digits by time-multiplexing: it scans digit enables and feeds the decoder one digit at a time.
- Adds leading-zero blanking and a game-over blink.
- Sits between the game logic (which produces score events) and the board's multiplexed 7-segment display.

Parameters:
- NUM_DIGITS, 4, number of BCD score digits (2..8).
- SCAN_DIV, 50000, clock cycles each digit stays enabled (>=2).
- BLINK_DIV, 64, number of full scan rotations per blink half-period (>=1).

Ports:
- clock  input  1  system clock.
- resetn  input  1  asynchronous, active-low reset.
- add_pulse  input  1  one-cycle request to add add_value; accepted only when add_ready=1.
- add_value  input  4  BCD value to add, 0..9; values 10..15 are treated as 9.
- add_ready  output  1  adder idle; a request is accepted this cycle.
- clear_score  input  1  synchronous clear of the score; highest priority.
- game_over  input  1  level signal; enables blinking.
- score_bcd  output  4*NUM_DIGITS  committed score; digit 0 in bits [3:0].
- digit_en  output  NUM_DIGITS  one-hot, active-high digit select.
- seg_out  output  7  active-low segments (1 = off), aligned with digit_en.

Behaviour:
- Reset (async, resetn=0):
  - score_bcd=0, add_ready=1, adder state IDLE.
  - Scan index 0, digit_en=1 (digit 0 selected), prescaler 0.
  - seg_out=7'h7F (blank), blink phase = visible.
- Adder FSM states: IDLE, ADD, COMMIT.
  - IDLE: add_ready=1. When add_pulse=1, latch add_value into the operand, copy score_bcd into a working register, set digit ptr=0, carry=0, and go to ADD.
  - ADD: one digit per cycle. sum = work[ptr] + (ptr==0 ? operand : 0) + carry. If sum>9, write sum-10 and set carry=1; otherwise write sum and set carry=0. After ptr==NUM_DIGITS-1, go to COMMIT. There is no early exit: ADD always takes exactly NUM_DIGITS cycles.
  - COMMIT: if the final carry is 1, score_bcd becomes all digits 9 (saturation). Otherwise score_bcd takes the working register. Then go to IDLE.
  - Latency: add_pulse at cycle t → new score_bcd visible at t+NUM_DIGITS+2; add_ready returns high in that same cycle.
  - add_pulse while add_ready=0 is ignored (dropped, not queued).
- clear_score=1, in any state:
  - Next cycle: score_bcd=0, FSM=IDLE, any in-flight add is discarded.
  - Overrides a simultaneous add_pulse.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1. At wrap, the index advances, wrapping from NUM_DIGITS-1 to 0.
  - digit_en is one-hot on the index.
  - Scanning runs continuously and is independent of the adder FSM.
- Display pipeline:
  - The selected digit is taken from score_bcd, never from the working register, so partial sums are never shown.
  - It is zero-extended to 5 bits into hex_seg. The decoder output is registered.
  - digit_en is registered in the same stage, so the two stay aligned with 1 cycle of latency.
- Blanking:
  - Digit i>0 is blank (7'h7F) if it and every higher digit are 0.
  - Digit 0 is never blanked by this rule.
- Blink:
  - The phase toggles every BLINK_DIV index wraps from NUM_DIGITS-1 to 0, and only while game_over=1.
  - While the phase is hidden, seg_out=7'h7F.
  - When game_over falls, the phase is forced visible on the next cycle.

Decomposition:
- Shared include asteroids_defs.vh holds:
  - adder state encodings (IDLE=2'd0, ADD=2'd1, COMMIT=2'd2);
  - SEG_BLANK=7'h7F;
  - BCD_MAX=4'd9.
- Sub-module: one hex_seg instance (the existing decoder), shared across digits through the scan mux. No other sub-modules.

Test Plan:
- Reset, then clear_score low and no adds, NUM_DIGITS=4 → score_bcd=16'h0000; a full scan shows digit 0 as "0" (7'b1000000) and digits 1..3 as 7'h7F.
- add 7, then add 5 (each after add_ready) → score_bcd=16'h0012. Check that add_ready stays low for exactly 5 cycles after each pulse, and that digit 1 shows "1" with digits 2..3 blank.
- Start from 16'h9998, add 9 → saturates to 16'h9999 at t+6.
- During ADD, pulse clear_score → score_bcd=16'h0000 next cycle, add_ready=1, and the in-flight add has no effect.
- add_pulse while add_ready=0 (second pulse 2 cycles after first, value 3) → score increases only by the first value.
- game_over=1, SCAN_DIV=2, BLINK_DIV=1 → seg_out is all 7'h7F on alternate rotations. Drop game_over → segments visible again on the next cycle.
